// File: rtl/m_circuit_5_stages_pipe_hz.sv
// Five-stage in-order RV32 subset core (IF, ID, EX, MA, WB) with full
// forwarding from MA and WB, a one-cycle load-use interlock, branches
// resolved in EX with a two-instruction flush, integrated instruction and
// data memories, a program-load port, a debug register read port and
// cycle/retire/stall counters. A register-file write to HALT_REG freezes
// the core until reset.
module m_circuit_5_stages_pipe_hz #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64,
    parameter int CNT_W      = 32,
    parameter int HALT_REG   = 30
) (
    input  logic                          w_clock,
    input  logic                          w_reset_n,
    input  logic                          w_imem_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] w_imem_addr,
    input  logic [31:0]                   w_imem_wdata,
    input  logic [4:0]                    w_dbg_ra,
    output logic [31:0]                   w_dbg_rd,
    output logic [31:0]                   w_pc,
    output logic                          w_halt,
    output logic                          w_stall,
    output logic                          w_flush,
    output logic [CNT_W-1:0]              w_cycles,
    output logic [CNT_W-1:0]              w_retired,
    output logic [CNT_W-1:0]              w_stalls
);

    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    // Instruction classes; every unsupported opcode collapses to OP_NOP.
    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_ADDI,
        OP_LW,
        OP_SW,
        OP_BNE
    } op_e;

    function automatic op_e decodeOp(input logic [4:0] opc);
        case (opc)
            5'b01100: decodeOp = OP_ADD;
            5'b00100: decodeOp = OP_ADDI;
            5'b00000: decodeOp = OP_LW;
            5'b01000: decodeOp = OP_SW;
            5'b11000: decodeOp = OP_BNE;
            default:  decodeOp = OP_NOP;
        endcase
    endfunction

    function automatic logic isWriter(input op_e op);
        isWriter = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LW);
    endfunction

    // Memories and architectural state
    logic [31:0] r_imem [IMEM_WORDS];
    logic [31:0] r_dmem [DMEM_WORDS];
    logic [31:0] r_regs [32];
    logic [31:0] r_pc;
    logic        r_halt;

    // IF/ID
    logic        r_idValid;
    logic [31:0] r_idPc;
    logic [31:0] r_idInstr;

    // ID/EX
    logic        r_exValid;
    op_e         r_exOp;
    logic [31:0] r_exPc;
    logic [4:0]  r_exRs1;
    logic [4:0]  r_exRs2;
    logic [4:0]  r_exRd;
    logic [31:0] r_exRs1Val;
    logic [31:0] r_exRs2Val;
    logic [31:0] r_exImm;

    // EX/MA
    logic        r_maValid;
    op_e         r_maOp;
    logic [4:0]  r_maRd;
    logic [31:0] r_maResult;
    logic [31:0] r_maStoreData;

    // MA/WB
    logic        r_wbValid;
    op_e         r_wbOp;
    logic [4:0]  r_wbRd;
    logic [31:0] r_wbResult;

    // Counters
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_stalls;

    // Combinational nets
    logic [31:0] w_ifInstr;
    op_e         w_idOp;
    logic [4:0]  w_idRs1;
    logic [4:0]  w_idRs2;
    logic [4:0]  w_idRd;
    logic [31:0] w_idImm;
    logic        w_idUsesRs1;
    logic        w_idUsesRs2;
    logic [31:0] w_idRs1Val;
    logic [31:0] w_idRs2Val;
    logic        w_maFwdOk;
    logic        w_wbWrite;
    logic [31:0] w_exOpA;
    logic [31:0] w_exOpB;
    logic [31:0] w_exResult;
    logic [31:0] w_exTarget;
    logic        w_branchTaken;
    logic        w_loadUse;
    logic        w_doFlush;
    logic        w_doStall;
    logic [DA-1:0] w_maAddr;
    logic [31:0] w_maLoad;
    logic [31:0] w_maWbValue;
    logic [4:0]  w_unusedInstrBits;

    // funct3 and the low opcode bits carry no meaning for this subset
    assign w_unusedInstrBits = {r_idInstr[14:12], r_idInstr[1:0]};

    // IF reads program memory combinationally at the current PC
    assign w_ifInstr = r_imem[r_pc[IA+1:2]];

    // ID field extraction and operand-usage flags
    assign w_idOp      = decodeOp(r_idInstr[6:2]);
    assign w_idRs1     = r_idInstr[19:15];
    assign w_idRs2     = r_idInstr[24:20];
    assign w_idRd      = r_idInstr[11:7];
    assign w_idUsesRs1 = (w_idOp != OP_NOP);
    assign w_idUsesRs2 = (w_idOp == OP_ADD) || (w_idOp == OP_SW) || (w_idOp == OP_BNE);

    // A valid WB register write with a nonzero destination
    assign w_wbWrite = r_wbValid && isWriter(r_wbOp) && (r_wbRd != 5'd0);

    // Pick the immediate format that matches the decoded instruction class
    always_comb begin
        w_idImm = {{20{r_idInstr[31]}}, r_idInstr[31:20]};
        case (w_idOp)
            OP_SW:   w_idImm = {{20{r_idInstr[31]}}, r_idInstr[31:25], r_idInstr[11:7]};
            OP_BNE:  w_idImm = {{19{r_idInstr[31]}}, r_idInstr[31], r_idInstr[7],
                                r_idInstr[30:25], r_idInstr[11:8], 1'b0};
            default: w_idImm = {{20{r_idInstr[31]}}, r_idInstr[31:20]};
        endcase
    end

    // Register read with write-through so an instruction in WB is seen by ID in the same cycle
    always_comb begin
        w_idRs1Val = r_regs[w_idRs1];
        w_idRs2Val = r_regs[w_idRs2];
        if (w_wbWrite && (r_wbRd == w_idRs1)) begin
            w_idRs1Val = r_wbResult;
        end
        if (w_wbWrite && (r_wbRd == w_idRs2)) begin
            w_idRs2Val = r_wbResult;
        end
    end

    // A load sitting in MA has no data yet, so only ALU producers forward from MA
    assign w_maFwdOk = r_maValid && isWriter(r_maOp) && (r_maOp != OP_LW) && (r_maRd != 5'd0);

    // EX operand selection: MA result beats WB result beats the ID/EX copy
    always_comb begin
        w_exOpA = r_exRs1Val;
        w_exOpB = r_exRs2Val;
        if (w_maFwdOk && (r_maRd == r_exRs1)) begin
            w_exOpA = r_maResult;
        end else if (w_wbWrite && (r_wbRd == r_exRs1)) begin
            w_exOpA = r_wbResult;
        end
        if (w_maFwdOk && (r_maRd == r_exRs2)) begin
            w_exOpB = r_maResult;
        end else if (w_wbWrite && (r_wbRd == r_exRs2)) begin
            w_exOpB = r_wbResult;
        end
    end

    // ALU: ADD uses both registers, everything else adds the immediate (ADDI value or LW/SW address)
    assign w_exResult    = (r_exOp == OP_ADD) ? (w_exOpA + w_exOpB) : (w_exOpA + r_exImm);
    assign w_exTarget    = r_exPc + r_exImm;
    assign w_branchTaken = r_exValid && (r_exOp == OP_BNE) && (w_exOpA != w_exOpB);

    // Load-use hazard: the consumer in ID needs a value the LW in EX has not loaded yet
    assign w_loadUse = r_exValid && (r_exOp == OP_LW) && (r_exRd != 5'd0) && r_idValid &&
                       ((w_idUsesRs1 && (w_idRs1 == r_exRd)) ||
                        (w_idUsesRs2 && (w_idRs2 == r_exRd)));

    // A flush discards the stalled ID instruction anyway, so it takes priority
    assign w_doFlush = w_branchTaken && !r_halt;
    assign w_doStall = w_loadUse && !w_branchTaken && !r_halt;

    // MA: word-addressed data memory, wrapping above its depth
    assign w_maAddr    = r_maResult[DA+1:2];
    assign w_maLoad    = r_dmem[w_maAddr];
    assign w_maWbValue = (r_maOp == OP_LW) ? w_maLoad : r_maResult;

    // Program-load port; deliberately unaffected by reset
    always_ff @(posedge w_clock) begin
        if (w_imem_we) begin
            r_imem[w_imem_addr] <= w_imem_wdata;
        end
    end

    // Stores commit on the clock edge while the SW is in MA
    always_ff @(posedge w_clock) begin
        if (!r_halt && r_maValid && (r_maOp == OP_SW)) begin
            r_dmem[w_maAddr] <= r_maStoreData;
        end
    end

    // Program counter: redirect on a taken branch, hold on stall or halt
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_pc <= 32'd0;
        end else if (!r_halt) begin
            if (w_doFlush) begin
                r_pc <= w_exTarget;
            end else if (!w_doStall) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // IF/ID register: cleared by a flush, held during a load-use stall
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_idValid <= 1'b0;
            r_idPc    <= 32'd0;
            r_idInstr <= 32'd0;
        end else if (!r_halt) begin
            if (w_doFlush) begin
                r_idValid <= 1'b0;
            end else if (!w_doStall) begin
                r_idValid <= 1'b1;
                r_idPc    <= r_pc;
                r_idInstr <= w_ifInstr;
            end
        end
    end

    // ID/EX register: a bubble enters on both a flush and a stall
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_exValid  <= 1'b0;
            r_exOp     <= OP_NOP;
            r_exPc     <= 32'd0;
            r_exRs1    <= 5'd0;
            r_exRs2    <= 5'd0;
            r_exRd     <= 5'd0;
            r_exRs1Val <= 32'd0;
            r_exRs2Val <= 32'd0;
            r_exImm    <= 32'd0;
        end else if (!r_halt) begin
            r_exValid  <= r_idValid && !w_doFlush && !w_doStall;
            r_exOp     <= w_idOp;
            r_exPc     <= r_idPc;
            r_exRs1    <= w_idRs1;
            r_exRs2    <= w_idRs2;
            r_exRd     <= w_idRd;
            r_exRs1Val <= w_idRs1Val;
            r_exRs2Val <= w_idRs2Val;
            r_exImm    <= w_idImm;
        end
    end

    // EX/MA register: the branch itself continues down the pipe and retires
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_maValid     <= 1'b0;
            r_maOp        <= OP_NOP;
            r_maRd        <= 5'd0;
            r_maResult    <= 32'd0;
            r_maStoreData <= 32'd0;
        end else if (!r_halt) begin
            r_maValid     <= r_exValid;
            r_maOp        <= r_exOp;
            r_maRd        <= r_exRd;
            r_maResult    <= w_exResult;
            r_maStoreData <= w_exOpB;
        end
    end

    // MA/WB register: carries either the ALU result or the loaded word
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_wbValid  <= 1'b0;
            r_wbOp     <= OP_NOP;
            r_wbRd     <= 5'd0;
            r_wbResult <= 32'd0;
        end else if (!r_halt) begin
            r_wbValid  <= r_maValid;
            r_wbOp     <= r_maOp;
            r_wbRd     <= r_maRd;
            r_wbResult <= w_maWbValue;
        end
    end

    // Register file write; x0 is never written so it always reads zero
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (!r_halt && w_wbWrite) begin
            r_regs[r_wbRd] <= r_wbResult;
        end
    end

    // Sticky halt, set by the edge that completes the write to HALT_REG
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_halt <= 1'b0;
        end else if (w_wbWrite && (r_wbRd == 5'(HALT_REG))) begin
            r_halt <= 1'b1;
        end
    end

    // Performance counters, frozen while halted and wrapping naturally
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_cycles  <= '0;
            r_retired <= '0;
            r_stalls  <= '0;
        end else if (!r_halt) begin
            r_cycles <= r_cycles + CNT_W'(1);
            if (r_wbValid) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_doStall) begin
                r_stalls <= r_stalls + CNT_W'(1);
            end
        end
    end

    assign w_dbg_rd  = (w_dbg_ra == 5'd0) ? 32'd0 : r_regs[w_dbg_ra];
    assign w_pc      = r_pc;
    assign w_halt    = r_halt;
    assign w_stall   = w_doStall;
    assign w_flush   = w_doFlush;
    assign w_cycles  = r_cycles;
    assign w_retired = r_retired;
    assign w_stalls  = r_stalls;

endmodule

// File: tb/tb_m_circuit_5_stages_pipe_hz.sv
// Directed bench for m_circuit_5_stages_pipe_hz: loads small programs,
// runs each to halt and compares register and counter results from a
// scoreboard queue filled when each program is set up.
module tb_m_circuit_5_stages_pipe_hz;

    localparam int IMEM_WORDS = 64;
    localparam int DMEM_WORDS = 64;
    localparam int CNT_W      = 32;
    localparam int IA         = $clog2(IMEM_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int K_REG     = 0;
    localparam int K_RETIRED = 1;
    localparam int K_STALLS  = 2;
    localparam int K_HALT    = 3;
    localparam int K_STALLCY = 4;
    localparam int K_FLUSHCY = 5;
    localparam int K_PC      = 6;
    localparam int K_CYCLES  = 7;
    localparam int K_STALLPC = 8;
    localparam int K_FLUSHPC = 9;

    logic              clock = 1'b0;
    logic              resetN = 1'b1;
    logic              imemWe = 1'b0;
    logic [IA-1:0]     imemAddr = '0;
    logic [31:0]       imemWdata = '0;
    logic [4:0]        dbgRa = '0;
    logic [31:0]       dbgRd;
    logic [31:0]       pc;
    logic              halt;
    logic              stall;
    logic              flush;
    logic [CNT_W-1:0]  cycles;
    logic [CNT_W-1:0]  retired;
    logic [CNT_W-1:0]  stalls;

    int checks = 0;
    int errors = 0;

    int          stallCycles = 0;
    int          flushCycles = 0;
    logic [31:0] stallPc = '0;
    logic [31:0] flushPc = '0;
    int          stallBase = 0;
    int          flushBase = 0;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] value;
    } exp_t;

    exp_t        scoreQ[$];
    logic [31:0] progQ[$];

    always #5 clock = ~clock;

    m_circuit_5_stages_pipe_hz #(
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_WORDS(DMEM_WORDS),
        .CNT_W(CNT_W),
        .HALT_REG(30)
    ) dut (
        .w_clock(clock),
        .w_reset_n(resetN),
        .w_imem_we(imemWe),
        .w_imem_addr(imemAddr),
        .w_imem_wdata(imemWdata),
        .w_dbg_ra(dbgRa),
        .w_dbg_rd(dbgRd),
        .w_pc(pc),
        .w_halt(halt),
        .w_stall(stall),
        .w_flush(flush),
        .w_cycles(cycles),
        .w_retired(retired),
        .w_stalls(stalls)
    );

    // Count stall and flush cycles mid-cycle, remembering the PC seen at each
    always @(negedge clock) begin
        if (resetN) begin
            if (stall) begin
                stallCycles = stallCycles + 1;
                stallPc     = pc;
            end
            if (flush) begin
                flushCycles = flushCycles + 1;
                flushPc     = pc;
            end
        end
    end

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] bne(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'h63};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input string tag, input int kind, input int idx, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.idx   = idx;
        e.value = value;
        scoreQ.push_back(e);
    endtask

    // Hold reset, write the queued program (NOP-filled) into imem, then release
    task automatic applyStimulus();
        @(negedge clock);
        resetN = 1'b0;
        for (int i = 0; i < IMEM_WORDS; i++) begin
            @(negedge clock);
            imemWe    = 1'b1;
            imemAddr  = IA'(i);
            imemWdata = (i < progQ.size()) ? progQ[i] : NOP;
        end
        @(negedge clock);
        imemWe = 1'b0;
        repeat (3) @(negedge clock);
        stallBase = stallCycles;
        flushBase = flushCycles;
        resetN    = 1'b1;
    endtask

    task automatic waitHalt(input string tag);
        int n = 0;
        while (halt !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, {31'd0, halt}, 32'd1);
    endtask

    // Pop every expectation and compare against the halted core
    task automatic drainQueue();
        exp_t        e;
        logic [31:0] obs;
        while (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            case (e.kind)
                K_REG: begin
                    dbgRa = 5'(e.idx);
                    #1;
                    obs = dbgRd;
                end
                K_RETIRED: obs = retired;
                K_STALLS:  obs = stalls;
                K_HALT:    obs = {31'd0, halt};
                K_STALLCY: obs = 32'(stallCycles - stallBase);
                K_FLUSHCY: obs = 32'(flushCycles - flushBase);
                K_PC:      obs = pc;
                K_CYCLES:  obs = cycles;
                K_STALLPC: obs = stallPc;
                default:   obs = flushPc;
            endcase
            checkOutput(e.tag, obs, e.value);
        end
    endtask

    task automatic loadProgram2();
        progQ.delete();
        progQ.push_back(addi(5'd1, 5'd0, 12'd5));
        progQ.push_back(addi(5'd2, 5'd1, 12'd3));
        progQ.push_back(add(5'd3, 5'd2, 5'd1));
        progQ.push_back(addi(5'd30, 5'd0, 12'd1));
    endtask

    task automatic expectProgram2(input string pfx);
        pushExp({pfx, "_x1"}, K_REG, 1, 32'd5);
        pushExp({pfx, "_x2"}, K_REG, 2, 32'd8);
        pushExp({pfx, "_x3"}, K_REG, 3, 32'd13);
        pushExp({pfx, "_x30"}, K_REG, 30, 32'd1);
        pushExp({pfx, "_x0"}, K_REG, 0, 32'd0);
        pushExp({pfx, "_retired"}, K_RETIRED, 0, 32'd4);
        pushExp({pfx, "_stalls"}, K_STALLS, 0, 32'd0);
        pushExp({pfx, "_halt"}, K_HALT, 0, 32'd1);
        pushExp({pfx, "_cycles"}, K_CYCLES, 0, 32'd8);
        pushExp({pfx, "_pc"}, K_PC, 0, 32'd32);
    endtask

    initial begin
        // Scenario 1: reset values, then the first active edge
        #2 resetN = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_pc", pc, 32'd0);
        checkOutput("rst_halt", {31'd0, halt}, 32'd0);
        checkOutput("rst_cycles", cycles, 32'd0);
        checkOutput("rst_retired", retired, 32'd0);
        checkOutput("rst_stalls", stalls, 32'd0);
        progQ.delete();
        applyStimulus();
        @(posedge clock);
        #1;
        checkOutput("first_edge_pc", pc, 32'd4);
        checkOutput("first_edge_cycles", cycles, 32'd1);

        // Scenario 2: forwarding chain and halt
        $display("[TB] scenario 2: forwarding");
        loadProgram2();
        expectProgram2("s2");
        applyStimulus();
        waitHalt("s2_halt_reached");
        drainQueue();

        // Scenario 3: store, load and a load-use stall
        $display("[TB] scenario 3: load-use");
        progQ.delete();
        progQ.push_back(addi(5'd1, 5'd0, 12'd7));
        progQ.push_back(sw(5'd1, 5'd0, 12'd8));
        progQ.push_back(lw(5'd2, 5'd0, 12'd8));
        progQ.push_back(addi(5'd3, 5'd2, 12'd1));
        progQ.push_back(addi(5'd30, 5'd0, 12'd1));
        pushExp("s3_x1", K_REG, 1, 32'd7);
        pushExp("s3_x2", K_REG, 2, 32'd7);
        pushExp("s3_x3", K_REG, 3, 32'd8);
        pushExp("s3_stalls", K_STALLS, 0, 32'd1);
        pushExp("s3_stall_cycles", K_STALLCY, 0, 32'd1);
        pushExp("s3_stall_pc", K_STALLPC, 0, 32'd16);
        pushExp("s3_retired", K_RETIRED, 0, 32'd5);
        applyStimulus();
        waitHalt("s3_halt_reached");
        drainQueue();

        // Scenario 4: taken branch flushes two younger instructions
        $display("[TB] scenario 4: taken branch");
        progQ.delete();
        progQ.push_back(addi(5'd1, 5'd0, 12'd1));
        progQ.push_back(bne(5'd1, 5'd0, 13'd12));
        progQ.push_back(addi(5'd5, 5'd0, 12'd9));
        progQ.push_back(addi(5'd7, 5'd0, 12'd9));
        progQ.push_back(addi(5'd6, 5'd0, 12'd4));
        progQ.push_back(addi(5'd30, 5'd0, 12'd1));
        pushExp("s4_x5", K_REG, 5, 32'd0);
        pushExp("s4_x7", K_REG, 7, 32'd0);
        pushExp("s4_x6", K_REG, 6, 32'd4);
        pushExp("s4_flush_cycles", K_FLUSHCY, 0, 32'd1);
        pushExp("s4_flush_pc", K_FLUSHPC, 0, 32'd12);
        pushExp("s4_retired", K_RETIRED, 0, 32'd4);
        pushExp("s4_stalls", K_STALLS, 0, 32'd0);
        applyStimulus();
        waitHalt("s4_halt_reached");
        drainQueue();

        // Scenario 5: untaken branch never flushes
        $display("[TB] scenario 5: untaken branch");
        progQ.delete();
        progQ.push_back(bne(5'd0, 5'd0, 13'd8));
        progQ.push_back(addi(5'd5, 5'd0, 12'd2));
        progQ.push_back(addi(5'd30, 5'd0, 12'd1));
        pushExp("s5_x5", K_REG, 5, 32'd2);
        pushExp("s5_flush_cycles", K_FLUSHCY, 0, 32'd0);
        pushExp("s5_retired", K_RETIRED, 0, 32'd3);
        applyStimulus();
        waitHalt("s5_halt_reached");
        drainQueue();

        // Scenario 6: asynchronous reset mid-run, rerun, then halt freeze
        $display("[TB] scenario 6: mid-run reset");
        loadProgram2();
        applyStimulus();
        repeat (6) @(posedge clock);
        #3;
        resetN = 1'b0;
        #1;
        checkOutput("s6_async_pc", pc, 32'd0);
        checkOutput("s6_async_retired", retired, 32'd0);
        for (int r = 1; r < 32; r++) begin
            dbgRa = 5'(r);
            #1;
            checkOutput($sformatf("s6_async_x%0d", r), dbgRd, 32'd0);
        end
        repeat (3) @(negedge clock);
        expectProgram2("s6");
        stallBase = stallCycles;
        flushBase = flushCycles;
        resetN    = 1'b1;
        waitHalt("s6_halt_reached");
        drainQueue();
        repeat (10) @(negedge clock);
        checkOutput("s6_frozen_pc", pc, 32'd32);
        checkOutput("s6_frozen_cycles", cycles, 32'd8);
        checkOutput("s6_frozen_retired", retired, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_circuit_5_stages_pipe_hz.md
Name: m_circuit_5_stages_pipe_hz

Overview:
Parametrised five-stage in-order RV32 subset core: IF, ID, EX, MA, WB.
- Full forwarding from both MA and WB.
- Load-use interlock with a one-cycle stall.
- Branch resolved in EX; on a taken branch, the two younger instructions are flushed.
- Integrated instruction and data memories, a program-load port, a debug register read port, and performance counters.

It is the top-level compute block that the simulator wrapper instantiates.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words; power of 2.
- DMEM_WORDS, 64, data memory depth in 32-bit words; power of 2.
- CNT_W, 32, width of the cycle, retire and stall counters.
- HALT_REG, 30, register index whose write halts the core.

Ports:
- w_clock, input, 1, rising-edge clock.
- w_reset_n, input, 1, asynchronous active-low reset.
- w_imem_we, input, 1, program-load write enable.
- w_imem_addr, input, $clog2(IMEM_WORDS), program-load word address.
- w_imem_wdata, input, 32, program-load instruction.
- w_dbg_ra, input, 5, debug register-file read address.
- w_dbg_rd, output, 32, value of x[w_dbg_ra], combinational; returns 0 for x0.
- w_pc, output, 32, current IF program counter.
- w_halt, output, 1, sticky halt flag.
- w_stall, output, 1, a load-use stall is inserted this cycle.
- w_flush, output, 1, a taken branch is flushing IF/ID and ID/EX this cycle.
- w_cycles, output, CNT_W, number of cycles since reset while not halted.
- w_retired, output, CNT_W, number of valid instructions that reached WB.
- w_stalls, output, CNT_W, number of load-use stall cycles.

Behaviour:
- Reset (asynchronous, while w_reset_n=0):
  - PC=0, all stage valid bits=0, x1..x31=0, counters=0, w_halt=0.
  - Instruction and data memory contents are not altered.
  - Writes on w_imem_we are accepted on any clock edge, including during reset. IF reads the memory combinationally.
- Supported instructions; all are decoded on opcode[6:2]:
  - ADD (01100): rd = rs1 + rs2.
  - ADDI (00100): rd = rs1 + sext(imm_i).
  - LW (00000): rd = dmem[(rs1 + imm_i)[k+1:2]].
  - SW (01000): dmem[(rs1 + imm_s)[k+1:2]] = rs2.
  - BNE (11000): if rs1 != rs2, then PC = PC_branch + imm_b.
  - Any other opcode is a NOP: no register write, no store, no branch.
  - funct fields are ignored. Address bits above the memory depth are ignored (wrap).
  - Writes to x0 are discarded.
- Pipeline, one instruction per cycle when unstalled:
  - IF: fetch imem[PC[k+1:2]]; next PC = PC+4.
  - ID: register read, with a write-through bypass when WB writes the same register in the same cycle.
  - EX: ALU and branch compare.
  - MA: data-memory read (combinational) or write (on the clock edge).
  - WB: register write.
- Forwarding:
  - EX operands take the MA-stage ALU result in preference to the WB-stage result, which in turn beats the register-file value.
  - A match requires a valid producer, producer rd != 0, and the producer being a register writer (ADD, ADDI or LW).
  - A MA-stage LW is never forwarded from MA.
- Load-use stall:
  - Condition: a valid LW in EX whose rd (nonzero) equals rs1 or rs2 of a valid ID instruction that uses that operand. ADDI and LW use rs1 only; ADD, SW and BNE use both.
  - Action: PC and IF/ID hold, a bubble is injected into EX, w_stall=1 for exactly 1 cycle, and w_stalls increments.
- Branch:
  - Condition: a valid BNE in EX that is taken.
  - Action: PC <= branch target, the IF/ID and ID/EX valid bits are cleared, w_flush=1 for 1 cycle. The branch penalty is 2 cycles.
  - If a flush and a stall coincide, the flush wins and no stall is counted.
- Halt:
  - Trigger: a valid WB write to HALT_REG.
  - The write itself completes, and w_halt=1 from the next cycle onward.
  - While halted, every pipeline register, the PC and all counters freeze. Only reset clears w_halt.
  - Instructions younger than the halting one do not retire.
- Counters:
  - w_cycles increments every unhalted cycle.
  - w_retired increments per valid WB instruction, including SW, BNE and NOP.
  - All counters wrap modulo 2^CNT_W.
- Stores: a valid SW in MA writes on the clock edge. A LW in the next cycle to the same address reads the new value.

Test Plan:
1. Assert reset for 3 cycles with no program, then release. Required: w_pc=0, w_halt=0, counters=0 during reset. w_pc=4 after the first active edge.
2. Program `addi x1,x0,5; addi x2,x1,3; add x3,x2,x1; addi x30,x0,1`. Required: x1=5, x2=8, x3=13, w_retired=4, w_stalls=0, w_halt=1.
3. Program `addi x1,x0,7; sw x1,8(x0); lw x2,8(x0); addi x3,x2,1; addi x30,x0,1`. Required: x3=8; w_stall high for exactly one cycle (when the addi is in ID); w_stalls=1.
4. Program `addi x1,x0,1; bne x1,x0,+12; addi x5,x0,9; addi x7,x0,9; addi x6,x0,4; addi x30,x0,1`. Required: x5=0, x7=0, x6=4; w_flush pulses once for one cycle.
5. Program `bne x0,x0,+8` (not taken) followed by `addi x5,x0,2`. Required: x5=2; w_flush is never asserted.
6. Pull w_reset_n low mid-run during scenario 2. Required: w_pc=0 and all x registers=0 immediately. After release, the program reruns to the same final values, with w_retired=4 counted from the new reset. After halt, w_pc and w_cycles stay constant for 10 cycles.
